ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_host_tx_if.sv | 11 +
 rtl/ps2_sync_edge.sv | 26 ++
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared state type, command bytes and parity helper for the PS/2 host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_RECOVER
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // PS/2 frames carry odd parity over the 8 data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       done;
  logic       ack_err;

  modport master (output tx_valid, tx_data, input tx_ready, done, ack_err);
  modport slave  (input tx_valid, tx_data, output tx_ready, done, ack_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus a one-cycle falling-edge pulse.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic d_sync,
  output logic fall
);
  logic meta_q, sync_q, prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign d_sync = sync_q;
  assign fall   = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request, shift, ACK, recover).
// Optional watchdog on device clock edges: define PS2_TX_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | lines released, ready for a command
// INHIBIT    | holding PS/2 clock low; data pulled low in the last cycle
// REQ        | start bit on data, waiting for the first device clock edge
// SHIFT      | data bits, parity, stop driven on device falling edges
// ACK        | stop released, device ACK sampled on the next falling edge
// RECOVER    | waiting for both lines high, then reporting the result
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);

  ps2_tx_state_t state, state_nxt;
  logic [IW-1:0] inh_cnt, inh_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic          par_q, par_nxt;
  logic [3:0]    idx_q, idx_nxt;
  logic          ok_q, ok_nxt;
  logic          done_nxt, err_nxt;
  logic          cur_bit;
  logic          clk_sync, clk_fall;
  logic          data_meta, data_sync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_q, wd_nxt;
`endif

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .d_in   (ps2_clk_in),
    .d_sync (clk_sync),
    .fall   (clk_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // Frame bit for the current index: data LSB-first, parity, then stop.
  always_comb begin
    if (idx_q < 4'd8)       cur_bit = byte_q[idx_q[2:0]];
    else if (idx_q == 4'd8) cur_bit = par_q;
    else                    cur_bit = 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    inh_nxt      = inh_cnt;
    byte_nxt     = byte_q;
    par_nxt      = par_q;
    idx_nxt      = idx_q;
    ok_nxt       = ok_q;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    ps2_clk_oe   = 1'b0;
    ps2_data_oe  = 1'b0;
    bus.tx_ready = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_nxt       = wd_q;
`endif
    case (state)
      ST_IDLE: begin
        bus.tx_ready = 1'b1;
        if (bus.tx_valid) begin
          byte_nxt  = bus.tx_data;
          par_nxt   = odd_parity(bus.tx_data);
          inh_nxt   = INH_LOAD;
          state_nxt = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == '0) begin
          ps2_data_oe = 1'b1;
          state_nxt   = ST_REQ;
`ifdef PS2_TX_TIMEOUT_EN
          wd_nxt      = WD_LOAD;
`endif
        end else begin
          inh_nxt = inh_cnt - 1'b1;
        end
      end
      ST_REQ: begin
        ps2_data_oe = 1'b1;
        if (clk_fall) begin
          idx_nxt   = 4'd0;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ps2_data_oe = ~cur_bit;
        if (clk_fall) begin
          idx_nxt = idx_q + 4'd1;
          if (idx_q == 4'd8) state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          ok_nxt    = ~data_sync;
          state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (clk_sync && data_sync) begin
          done_nxt  = ok_q;
          err_nxt   = ~ok_q;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Any device edge while the device owns the clock restarts the watchdog.
    if (state inside {ST_REQ, ST_SHIFT, ST_ACK}) begin
      if (clk_fall) begin
        wd_nxt = WD_LOAD;
      end else if (wd_q == '0) begin
        state_nxt   = ST_IDLE;
        err_nxt     = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
      end else begin
        wd_nxt = wd_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      inh_cnt     <= '0;
      byte_q      <= '0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      ok_q        <= 1'b0;
      bus.done    <= 1'b0;
      bus.ack_err <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state       <= state_nxt;
      inh_cnt     <= inh_nxt;
      byte_q      <= byte_nxt;
      par_q       <= par_nxt;
      idx_q       <= idx_nxt;
      ok_q        <= ok_nxt;
      bus.done    <= done_nxt;
      bus.ack_err <= err_nxt;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q        <= wd_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and random PS/2 host transmit frames against a behavioural device model.
import ps2_pkg::*;

module tb_ps2_host_tx;
  localparam int INH = 4;
  localparam int TMO = 100;

  logic clk;
  logic reset;
  logic dev_clk, dev_data;
  logic ps2_clk_in, ps2_data_in;
  logic ps2_clk_oe, ps2_data_oe;
  int   n_pass;
  int   n_total;

  ps2_host_tx_if bus ();

  // Open-drain lines: either side may pull low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One host frame; the expected line pattern comes from the PS/2 frame definition.
  task automatic xfer(input logic [7:0] b, input bit dev_ack, input int glitch_at,
                      input int abort_at);
    logic [9:0] frame;
    int ones, n, dcnt, nd, ne;
    logic dlast;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    frame[7:0] = b;
    frame[8]   = ((ones % 2) == 0);
    frame[9]   = 1'b1;

    @(negedge clk);
    chk("ready_idle", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~b;

    n = 0; dcnt = 0; dlast = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < 50) begin
      n++;
      dlast = ps2_data_oe;
      dcnt += int'(ps2_data_oe);
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("inhibit_data_last", dlast, 1);
    chk("inhibit_data_cnt", dcnt, 1);
    chk("start_clk_oe", ps2_clk_oe, 0);
    chk("start_bit", ps2_data_oe, 1);

    for (int k = 0; k < 10; k++) begin
      repeat (4) @(negedge clk);
      dev_clk = 1'b0;
      repeat (6) @(negedge clk);
      chk($sformatf("bit%0d_%02h", k, b), ps2_data_oe, !frame[k]);
      if (k == glitch_at) begin
        chk("ready_busy", bus.tx_ready, 0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = PS2_CMD_RESET;
      end
      if (k == 8) bus.tx_valid = 1'b0;
      dev_clk = 1'b1;
      if (k == abort_at) begin
        @(negedge clk);
        reset        = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = PS2_CMD_ENABLE;
        @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_ready", bus.tx_ready, 1);
        reset        = 1'b0;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        chk("rst_no_accept", ps2_clk_oe, 0);
        return;
      end
    end

    repeat (4) @(negedge clk);
    dev_data = !dev_ack;
    repeat (2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (6) @(negedge clk);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    dev_data = 1'b1;

    nd = 0; ne = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      nd += int'(bus.done);
      ne += int'(bus.ack_err);
    end
    chk("done_pulses", nd, dev_ack ? 1 : 0);
    chk("err_pulses", ne, dev_ack ? 0 : 1);
    chk("end_ready", bus.tx_ready, 1);
    chk("end_clk_oe", ps2_clk_oe, 0);
    chk("end_data_oe", ps2_data_oe, 0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = PS2_CMD_SET_LED;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.tx_ready, 1);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_data_oe", ps2_data_oe, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.ack_err, 0);
    reset = 1'b0;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    chk("reset_no_accept", ps2_clk_oe, 0);

    xfer(PS2_CMD_SET_LED, 1'b1, -1, -1);
    xfer(8'h00, 1'b1, -1, -1);
    xfer(8'($urandom), 1'b0, -1, -1);
    xfer(8'h3C, 1'b1, 3, -1);
    xfer(8'hA5, 1'b1, -1, 2);
    xfer(PS2_CMD_ENABLE, 1'b1, -1, -1);
    for (int r = 0; r < 4; r++) begin
      xfer(8'($urandom), 1'($urandom_range(0, 1)), -1, -1);
    end

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = PS2_CMD_RESET;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      n = 0;
      while (ps2_clk_oe === 1'b1 && n < 50) begin
        n++;
        @(negedge clk);
      end
      n = 0;
      while (bus.ack_err !== 1'b1 && n < 300) begin
        n++;
        @(negedge clk);
      end
      chk("timeout_cycles", n, TMO);
      chk("timeout_clk_oe", ps2_clk_oe, 0);
      chk("timeout_data_oe", ps2_data_oe, 0);
      chk("timeout_done", bus.done, 0);
      chk("timeout_ready", bus.tx_ready, 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
